// File: rtl/fetch_decode_queue_if.sv
// IF/ID handshake bundle: fetch pushes {pc, instruction, halt} in, decode pops the head out.
// The queue sits on the slave side; the fetch/decode pair drives the master side.
interface fetch_decode_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instruction;
  logic [XLEN-1:0] in_pc;
  logic            in_halt;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instruction;
  logic [XLEN-1:0] out_pc;
  logic            out_halt;

  modport master (
    output in_valid,
    input  in_ready,
    output in_instruction,
    output in_pc,
    output in_halt,
    input  out_valid,
    output out_ready,
    input  out_instruction,
    input  out_pc,
    input  out_halt
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_instruction,
    input  in_pc,
    input  in_halt,
    output out_valid,
    input  out_ready,
    output out_instruction,
    output out_pc,
    output out_halt
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// IF/ID boundary: small circular FIFO of fetched {pc, instruction, halt} words.
// Flush drops everything queued; a halt-marked word closes the input until flush or reset.
module fetch_decode_queue #(
  parameter int unsigned     DEPTH = 2,
  parameter int unsigned     XLEN  = 32,
  parameter logic [XLEN-1:0] NOP   = XLEN'(32'h00000013)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  fetch_decode_queue_if.slave    bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   halted
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic            halt_mem  [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            halted_q, halted_d;

  logic in_ready, out_valid, push, pop;

  // Flush masks both handshakes in its own cycle so nothing moves on that edge.
  always_comb begin
    in_ready  = (count_q != CntFull) & ~halted_q & ~flush;
    out_valid = (count_q != '0) & ~flush;
    push      = bus.in_valid & in_ready;
    pop       = out_valid & bus.out_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (bus.in_halt) begin
          halted_d = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // Payload needs no reset: it is only ever observed through a valid head.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= bus.in_pc;
      instr_mem[wr_ptr_q] <= bus.in_instruction;
      halt_mem[wr_ptr_q]  <= bus.in_halt;
    end
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    if (out_valid) begin
      bus.out_pc          = pc_mem[rd_ptr_q];
      bus.out_instruction = instr_mem[rd_ptr_q];
      bus.out_halt        = halt_mem[rd_ptr_q];
    end else begin
      bus.out_pc          = '0;
      bus.out_instruction = NOP;
      bus.out_halt        = 1'b0;
    end
    count  = count_q;
    halted = halted_q;
  end

  a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= CntFull);

  a_ptr_consistent : assert property (@(posedge clk) disable iff (rst)
    PtrW'(wr_ptr_q - rd_ptr_q) == PtrW'(count_q));

  a_head_known : assert property (@(posedge clk) disable iff (rst)
    bus.out_valid |-> !$isunknown({bus.out_pc, bus.out_instruction, bus.out_halt}));

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized bench for fetch_decode_queue against a queue-based reference model,
// preceded by the directed IF/ID scenarios (fill, drain, streaming, halt, flush, async reset).
`timescale 1ns/1ps
module tb_fetch_decode_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        halt;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic halted;

  fetch_decode_queue_if #(.XLEN(XLEN)) bus ();

  fetch_decode_queue #(
    .DEPTH(DEPTH),
    .XLEN (XLEN),
    .NOP  (NOP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  entry_t model_q[$];
  logic   model_halted = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance model, wait posedge.
  task automatic cycle(input logic f, input logic v, input logic [31:0] pc,
                       input logic [31:0] instr, input logic h, input logic r);
    logic   exp_in_ready, exp_out_valid;
    entry_t head, e;
    @(negedge clk);
    flush              = f;
    bus.in_valid       = v;
    bus.in_pc          = pc;
    bus.in_instruction = instr;
    bus.in_halt        = h;
    bus.out_ready      = r;
    #1;
    exp_in_ready  = (model_q.size() < DEPTH) && !model_halted && !f;
    exp_out_valid = (model_q.size() != 0) && !f;
    head = exp_out_valid ? model_q[0] : '{pc: 32'h0, instr: NOP, halt: 1'b0};
    check_eq("in_ready", 64'(bus.in_ready), 64'(exp_in_ready));
    check_eq("out_valid", 64'(bus.out_valid), 64'(exp_out_valid));
    check_eq("out_pc", 64'(bus.out_pc), 64'(head.pc));
    check_eq("out_instruction", 64'(bus.out_instruction), 64'(head.instr));
    check_eq("out_halt", 64'(bus.out_halt), 64'(head.halt));
    check_eq("count", 64'(count), 64'(model_q.size()));
    check_eq("halted", 64'(halted), 64'(model_halted));
    if (f) begin
      model_q.delete();
      model_halted = 1'b0;
    end else begin
      if (exp_out_valid && r) void'(model_q.pop_front());
      if (exp_in_ready && v) begin
        e = '{pc: pc, instr: instr, halt: h};
        model_q.push_back(e);
        if (h) model_halted = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_pc          = '0;
    bus.in_instruction = '0;
    bus.in_halt        = 1'b0;
    bus.out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    idle();

    // Fill with decode stalled
    cycle(1'b0, 1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h4, 32'h00A00113, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h8, 32'h12345678, 1'b0, 1'b0);

    // Drain from full
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Streaming push+pop with pointer wrap
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 32'(i * 4), 32'h00100093 + 32'(i), 1'b0, (i != 0));
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Halt closes the input; following word must not be enqueued
    cycle(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'hC, 32'h00000093, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'hC, 32'h00000093, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'hC, 32'h00000093, 1'b0, 1'b1);

    // Flush with simultaneous push and pop at count=2
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h20, 32'h00200093, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h24, 32'h00300093, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h40, 32'h00400093, 1'b0, 1'b1);
    idle();

    // Asynchronous reset mid-cycle with one entry queued
    cycle(1'b0, 1'b1, 32'h50, 32'h00500093, 1'b0, 1'b0);
    @(negedge clk);
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_eq("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
    #1 rst = 1'b1;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check_eq("rst_out_pc", 64'(bus.out_pc), 64'(0));
    check_eq("rst_out_instruction", 64'(bus.out_instruction), 64'(NOP));
    check_eq("rst_count", 64'(count), 64'(0));
    #1 rst = 1'b0;
    #0.5;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'(1));
    model_q.delete();
    model_halted = 1'b0;
    @(posedge clk);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 11) == 0),
            ($urandom_range(0, 9) < 7),
            {$urandom_range(0, 32'h3FFF), 2'b00},
            $urandom(),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
